uart_fifo_ctrl: RTL
===================

Name: uart_fifo_ctrl

Overview:
Parametrised single-clock UART subsystem that supersedes the fixed 8-bit TX-FIFO/UART/RX-buffer chain.
- Transmit path: host writes words into a TX FIFO; a TX engine serialises them with configurable parity and stop bits.
- Receive path: an RX engine deserialises RXD into an RX FIFO that the host pops.
- Extras: sticky error flags, active-low interrupts, internal loopback for self-test.

Parameters:
DATA_W, 8, data bits per frame (5..9)
DEPTH, 16, entries per FIFO (power of 2, >=2)
CLKS_PER_BIT, 16, CLOCK cycles per bit (even, >=4)
PARITY, 0, 0 none / 1 odd / 2 even
STOP_BITS, 1, 1 or 2 stop bits transmitted

Ports:
CLOCK  in  1  system clock, all logic on rising edge
RESET  in  1  asynchronous, active-high reset
WR_EN  in  1  push DATA_IN into TX FIFO
DATA_IN  in  DATA_W  TX write data
RD_EN  in  1  pop head of RX FIFO
DATA_OUT  out  DATA_W  RX FIFO head, first-word-fall-through
TX_FULL  out  1  TX FIFO full
TX_EMPTY  out  1  TX FIFO empty
RX_EMPTY  out  1  RX FIFO empty
RX_FULL  out  1  RX FIFO full
TXD  out  1  serial out, idle high
RXD  in  1  serial in, asynchronous
LOOPBACK  in  1  1 = RX fed from internal TX, TXD pin held high
CLR_ERR  in  1  clear all sticky error flags
NINTO  out  1  low when TX FIFO empty and TX engine idle
NINTI  out  1  low when RX FIFO non-empty
PAR_ERR  out  1  sticky parity error
FRM_ERR  out  1  sticky framing error
OVR_ERR  out  1  sticky overrun

Behaviour:
Reset values (asynchronous):
- Pointers and counters 0; both FSMs IDLE; TXD=1.
- TX_EMPTY=1, RX_EMPTY=1, TX_FULL=0, RX_FULL=0.
- NINTO=1, NINTI=1, all error flags 0, DATA_OUT=0.
- Reset mid-frame aborts the frame immediately; FIFO contents are lost.

FIFOs:
- Circular, with log2(DEPTH)+1-bit pointers; full/empty come from the MSB compare.
- WR_EN while full: ignored, no error flag.
- RD_EN while empty: ignored.
- Simultaneous push and pop on a non-empty, non-full FIFO: both take effect; count unchanged.
- DATA_OUT shows the RX head combinationally; it is 0 when empty.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- IDLE with TX FIFO non-empty: pop the head into the shift register; enter START next cycle.
- Each bit is held for exactly CLKS_PER_BIT cycles; data goes LSB first.
- PARITY state is skipped when PARITY=0.
- STOP holds TXD=1 for STOP_BITS bit periods, then returns to IDLE. Back-to-back frames carry no extra idle bit.
- Latency: WR_EN at cycle 0 into an empty, idle block gives TXD falling at the cycle 2 edge.
- NINTO deasserts (high) on the cycle the FIFO becomes non-empty or the engine leaves IDLE.

RX FSM (IDLE, START, DATA, PARITY, STOP):
- RXD passes through a 2-flop synchroniser; in loopback the internal TX bit is used directly, unsynchronised.
- IDLE: a 1-to-0 transition starts a count of CLKS_PER_BIT/2. If the line is still 0 at that point, go to DATA; otherwise treat it as a glitch and return to IDLE.
- All later samples are taken every CLKS_PER_BIT cycles (bit centres).
- PARITY: compare against the computed value; a mismatch sets PAR_ERR, and the word is still stored.
- STOP: only the first stop bit is checked.
  - Stop bit 0: set FRM_ERR, discard the word.
  - RX FIFO full: set OVR_ERR, drop the new word; existing contents are unchanged.
  - Otherwise push. The pushed word is visible on DATA_OUT and NINTI goes low the following cycle.
- Return to IDLE at the stop-bit centre, ready for the next start edge.

Error flags:
- Sticky until CLR_ERR.
- If CLR_ERR coincides with a new error event, the flag remains set.

LOOPBACK:
- Takes effect immediately.
- A frame in flight when it toggles may be corrupted; the flags report any resulting error.

Test Plan:
- Single frame, DATA_W=8, CLKS_PER_BIT=4, PARITY=0, loopback: write 0xA5 -> TXD pin stays 1; after 40+ cycles DATA_OUT=0xA5, NINTI=0, NINTO=0, no error flags.
- TX timing, PARITY=2, STOP_BITS=2: write 0x03 -> TXD sequence 0,1,1,0,0,0,0,0,0,0(parity even),1,1, each bit held 4 cycles; TXD falls at cycle 2.
- FIFO bounds, DEPTH=4: 5 writes with TX stalled by reset-release timing -> 5th write ignored, TX_FULL=1; RD_EN on empty RX -> no change, RX_EMPTY=1.
- Overrun, DEPTH=4: loop back 5 frames with no reads -> RX holds the first 4 words, OVR_ERR=1; CLR_ERR -> OVR_ERR=0.
- Error injection on external RXD: frame with stop bit 0 -> FRM_ERR=1, nothing stored; frame with wrong parity (PARITY=1) -> PAR_ERR=1, word stored. A 1-cycle low glitch on RXD -> no frame, no flags.
- Reset mid-frame: assert RESET during DATA bit 3 -> TXD=1 and flags cleared immediately (asynchronously); the next write transmits cleanly.

Source files
------------

// File: rtl/uart_fifo_ctrl.sv
// UART subsystem: TX FIFO -> serialiser, deserialiser -> RX FIFO, with
// configurable parity/stop bits, sticky error flags, interrupts and loopback.
module uart_fifo_ctrl #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              WR_EN,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              RD_EN,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              TX_FULL,
    output logic              TX_EMPTY,
    output logic              RX_EMPTY,
    output logic              RX_FULL,
    output logic              TXD,
    input  logic              RXD,
    input  logic              LOOPBACK,
    input  logic              CLR_ERR,
    output logic              NINTO,
    output logic              NINTI,
    output logic              PAR_ERR,
    output logic              FRM_ERR,
    output logic              OVR_ERR
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_W);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    // Value of the parity bit that accompanies data word d.
    function automatic logic parity_bit(input logic [DATA_W-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] tx_mem [DEPTH];
    logic [PW-1:0]     tx_wptr_q, tx_rptr_q, tx_wptr_d, tx_rptr_d;
    logic              tx_push, tx_load, tx_empty_d;
    logic [DATA_W-1:0] tx_head;

    assign TX_EMPTY = (tx_wptr_q == tx_rptr_q);
    assign TX_FULL  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                      (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
    assign tx_push  = WR_EN && !TX_FULL;
    assign tx_head  = tx_mem[tx_rptr_q[AW-1:0]];

    always_comb begin
        tx_wptr_d  = tx_wptr_q + PW'(tx_push);
        tx_rptr_d  = tx_rptr_q + PW'(tx_load);
        tx_empty_d = (tx_wptr_d == tx_rptr_d);
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= DATA_IN;
    end

    // ---------------- TX engine ----------------
    state_e            tx_state_q;
    logic [CW-1:0]     tx_cnt_q;
    logic [BW-1:0]     tx_bit_q;
    logic              tx_stop_q;
    logic [DATA_W-1:0] tx_sh_q;
    logic              tx_par_q;
    logic              tx_txd_q;
    logic              ninto_q;
    logic              tx_bit_done, tx_frame_end, tx_idle_d;

    assign tx_bit_done  = (tx_cnt_q == CW'(CLKS_PER_BIT - 1));
    assign tx_frame_end = (tx_state_q == S_STOP) && tx_bit_done &&
                          (tx_stop_q == 1'(STOP_BITS - 1));
    // A new frame starts straight from IDLE or from the end of the last stop bit.
    assign tx_load      = !TX_EMPTY && ((tx_state_q == S_IDLE) || tx_frame_end);
    assign tx_idle_d    = !tx_load && ((tx_state_q == S_IDLE) || tx_frame_end);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_txd_q   <= 1'b1;
        end else if (tx_load) begin
            tx_state_q <= S_START;
            tx_cnt_q   <= '0;
            tx_sh_q    <= tx_head;
            tx_par_q   <= parity_bit(tx_head);
            tx_txd_q   <= 1'b0;
        end else begin
            tx_cnt_q <= tx_bit_done ? '0 : tx_cnt_q + CW'(1);
            case (tx_state_q)
                S_IDLE: begin
                    tx_cnt_q <= '0;
                    tx_txd_q <= 1'b1;
                end
                S_START: begin
                    if (tx_bit_done) begin
                        tx_state_q <= S_DATA;
                        tx_bit_q   <= '0;
                        tx_txd_q   <= tx_sh_q[0];
                        tx_sh_q    <= tx_sh_q >> 1;
                    end
                end
                S_DATA: begin
                    if (tx_bit_done) begin
                        if (tx_bit_q == BW'(DATA_W - 1)) begin
                            if (PARITY != 0) begin
                                tx_state_q <= S_PARITY;
                                tx_txd_q   <= tx_par_q;
                            end else begin
                                tx_state_q <= S_STOP;
                                tx_stop_q  <= 1'b0;
                                tx_txd_q   <= 1'b1;
                            end
                        end else begin
                            tx_bit_q <= tx_bit_q + BW'(1);
                            tx_txd_q <= tx_sh_q[0];
                            tx_sh_q  <= tx_sh_q >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tx_bit_done) begin
                        tx_state_q <= S_STOP;
                        tx_stop_q  <= 1'b0;
                        tx_txd_q   <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_frame_end)     tx_state_q <= S_IDLE;
                    else if (tx_bit_done) tx_stop_q  <= 1'b1;
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    // Registered from next-state values so it tracks the FIFO/engine without lag.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) ninto_q <= 1'b1;
        else       ninto_q <= !(tx_empty_d && tx_idle_d);
    end

    assign TXD   = LOOPBACK ? 1'b1 : tx_txd_q;
    assign NINTO = ninto_q;

    // ---------------- RX engine ----------------
    logic              rxd_s1_q, rxd_s2_q, rx_prev_q;
    logic              rx_bit;
    state_e            rx_state_q;
    logic [CW-1:0]     rx_cnt_q;
    logic [BW-1:0]     rx_bit_q;
    logic [DATA_W-1:0] rx_sh_q;
    logic              rx_bit_done, rx_half_done, rx_stop_smp;
    logic              rx_push, rx_pop, par_ev, frm_ev, ovr_ev;

    assign rx_bit       = LOOPBACK ? tx_txd_q : rxd_s2_q;
    assign rx_bit_done  = (rx_cnt_q == CW'(CLKS_PER_BIT - 1));
    assign rx_half_done = (rx_cnt_q == CW'(CLKS_PER_BIT / 2 - 1));
    assign rx_stop_smp  = (rx_state_q == S_STOP) && rx_bit_done;
    assign par_ev       = (rx_state_q == S_PARITY) && rx_bit_done &&
                          (rx_bit != parity_bit(rx_sh_q));
    assign frm_ev       = rx_stop_smp && !rx_bit;
    assign ovr_ev       = rx_stop_smp && rx_bit && RX_FULL;
    assign rx_push      = rx_stop_smp && rx_bit && !RX_FULL;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            rxd_s1_q  <= 1'b1;
            rxd_s2_q  <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rxd_s1_q  <= RXD;
            rxd_s2_q  <= rxd_s1_q;
            rx_prev_q <= rx_bit;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            rx_cnt_q <= rx_bit_done ? '0 : rx_cnt_q + CW'(1);
            case (rx_state_q)
                S_IDLE: begin
                    rx_cnt_q <= '0;
                    if (rx_prev_q && !rx_bit) rx_state_q <= S_START;
                end
                S_START: begin
                    // Confirm the start bit at its centre; a high line here was a glitch.
                    if (rx_half_done) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_bit ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (rx_bit_done) begin
                        rx_sh_q <= {rx_bit, rx_sh_q[DATA_W-1:1]};
                        if (rx_bit_q == BW'(DATA_W - 1))
                            rx_state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        else
                            rx_bit_q <= rx_bit_q + BW'(1);
                    end
                end
                S_PARITY: if (rx_bit_done) rx_state_q <= S_STOP;
                S_STOP:   if (rx_bit_done) rx_state_q <= S_IDLE;
                default:  rx_state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_W-1:0] rx_mem [DEPTH];
    logic [PW-1:0]     rx_wptr_q, rx_rptr_q;

    assign RX_EMPTY = (rx_wptr_q == rx_rptr_q);
    assign RX_FULL  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                      (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
    assign rx_pop   = RD_EN && !RX_EMPTY;
    assign DATA_OUT = RX_EMPTY ? '0 : rx_mem[rx_rptr_q[AW-1:0]];
    assign NINTI    = RX_EMPTY;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            rx_wptr_q <= rx_wptr_q + PW'(rx_push);
            rx_rptr_q <= rx_rptr_q + PW'(rx_pop);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= rx_sh_q;
    end

    // ---------------- Sticky error flags ----------------
    logic par_err_q, frm_err_q, ovr_err_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            par_err_q <= par_ev | (par_err_q & ~CLR_ERR);
            frm_err_q <= frm_ev | (frm_err_q & ~CLR_ERR);
            ovr_err_q <= ovr_ev | (ovr_err_q & ~CLR_ERR);
        end
    end

    assign PAR_ERR = par_err_q;
    assign FRM_ERR = frm_err_q;
    assign OVR_ERR = ovr_err_q;

endmodule
